// File: rtl/button_edge_ctrl.sv
// Debounced push-button controller: per-bit synchronizer and debounce counter,
// rising-edge capture register with write-1-to-clear, maskable level interrupt.
module button_edge_ctrl #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_STABLE = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

  logic [WIDTH-1:0]            sync1_reg;
  logic [WIDTH-1:0]            sync2_reg;
  logic [WIDTH-1:0]            stable_reg;
  logic [WIDTH-1:0]            stable_next;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0]            edge_reg;
  logic [WIDTH-1:0]            edge_next;
  logic [WIDTH-1:0]            edge_clr;
  logic [WIDTH-1:0]            rise;
  logic [WIDTH-1:0]            mask_reg;
  logic [CNT_W-1:0]            period_reg;
  logic [CNT_W-1:0]            p_minus1;
  logic [31:0]                 rd_mux;
  logic                        wr_en;
  logic                        rd_en;
  logic                        period_wr;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign period_wr = wr_en & (address == ADDR_PERIOD);
  assign edge_clr  = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // A period of zero behaves like a period of one: terminal count is 0 either way.
  assign p_minus1 = (period_reg == '0) ? '0 : period_reg - CNT_W'(1);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
      logic match;
      logic done;

      assign match           = (sync2_reg[gi] == stable_reg[gi]);
      assign done            = (cnt_reg[gi] == p_minus1);
      assign stable_next[gi] = (!match && done) ? sync2_reg[gi] : stable_reg[gi];
      // A period write restarts every pending debounce from zero.
      assign cnt_next[gi]    = (period_wr || match || done) ? '0
                                                            : cnt_reg[gi] + CNT_W'(1);
    end
  endgenerate

  assign rise = stable_next & ~stable_reg;

  // A new rising edge takes priority over a simultaneous write-1-to-clear.
  assign edge_next = (edge_reg & ~edge_clr) | rise;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STABLE: rd_mux[WIDTH-1:0] = stable_reg;
      ADDR_MASK:   rd_mux[WIDTH-1:0] = mask_reg;
      ADDR_PERIOD: rd_mux[CNT_W-1:0] = period_reg;
      ADDR_EDGE:   rd_mux[WIDTH-1:0] = edge_reg;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      stable_reg <= '0;
      cnt_reg    <= '0;
      edge_reg   <= '0;
      mask_reg   <= '0;
      period_reg <= CNT_W'(DEF_PERIOD);
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      sync1_reg  <= in_port;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
      edge_reg   <= edge_next;
      irq        <= |(edge_reg & mask_reg);
      if (wr_en && (address == ADDR_MASK)) begin
        mask_reg <= writedata[WIDTH-1:0];
      end
      if (period_wr) begin
        period_reg <= writedata[CNT_W-1:0];
      end
      // Read mux sees pre-write register values, so read-during-write returns old data.
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_button_edge_ctrl.sv
// Directed bench for button_edge_ctrl; read responses (and irq alongside them)
// are checked against a scoreboard by an independent monitor process.
module tb_button_edge_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [31:0] sb_data[$];
  int          sb_irq[$];
  string       sb_name[$];

  button_edge_ctrl #(.WIDTH(4), .CNT_W(16), .DEF_PERIOD(50000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  // exp_irq < 0 skips the irq comparison for this transaction
  task automatic rd(input logic [1:0] a, input logic [31:0] exp_d, input int exp_irq,
                    input string name);
    sb_data.push_back(exp_d);
    sb_irq.push_back(exp_irq);
    sb_name.push_back(name);
    chipselect = 1'b1; read = 1'b1; address = a;
    step();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp_d,
                      input int exp_irq, input string name);
    sb_data.push_back(exp_d);
    sb_irq.push_back(exp_irq);
    sb_name.push_back(name);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  // Monitor: a read strobe seen at a clock edge yields readdata after that edge.
  initial begin
    logic [31:0] e_d;
    int          e_i;
    string       e_n;
    forever begin
      @(posedge clk);
      if (reset_n && chipselect && read) begin
        @(negedge clk);
        if (sb_data.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_read: readdata=0x%08h with no expected entry", readdata);
        end else begin
          e_d = sb_data.pop_front();
          e_i = sb_irq.pop_front();
          e_n = sb_name.pop_front();
          check_cnt++;
          if (readdata === e_d) begin
            pass_cnt++;
            $display("read  %-16s data=0x%08h ok", e_n, readdata);
          end else begin
            $display("FAIL %s: readdata=0x%08h expected 0x%08h", e_n, readdata, e_d);
          end
          if (e_i >= 0) begin
            check_cnt++;
            if (irq === e_i[0]) pass_cnt++;
            else $display("FAIL %s_irq: irq=%0b expected %0d", e_n, irq, e_i);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; in_port = '0;
    idle(3);
    reset_n = 1'b1;
    step();

    // reset state
    rd(2'd0, 32'h0, 0, "rst_stable");
    rd(2'd1, 32'h0, 0, "rst_mask");
    rd(2'd2, 32'h0000C350, 0, "rst_period");
    rd(2'd3, 32'h0, 0, "rst_edge");

    // register access: RO stable, upper bits zero
    wr(2'd2, 32'd4);
    wr(2'd0, 32'hF);
    rd(2'd0, 32'h0, 0, "stable_ro");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0000000F, 0, "mask_width");
    wr(2'd1, 32'h1);
    rd(2'd2, 32'h4, 0, "period4");

    // clean rise on bit0: stable at edge 6 after the change, irq one later
    in_port = 4'h1;
    idle(5);
    rd(2'd0, 32'h0, 0, "rise_early");
    rd(2'd0, 32'h1, 1, "rise_stable");
    rd(2'd3, 32'h1, 1, "rise_edge");

    // W1C, then falling edge sets nothing
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, 0, "w1c_clear");
    in_port = 4'h0;
    idle(8);
    rd(2'd0, 32'h0, 0, "fall_stable");
    rd(2'd3, 32'h0, 0, "fall_no_edge");

    // 3-cycle glitch is rejected
    in_port = 4'h1;
    idle(3);
    in_port = 4'h0;
    idle(6);
    rd(2'd0, 32'h0, 0, "glitch_stable");
    rd(2'd3, 32'h0, 0, "glitch_edge");

    // full debounce after glitch proves the counter restarted from 0
    in_port = 4'h3;
    idle(5);
    rd(2'd0, 32'h0, 0, "both_early");
    rd(2'd0, 32'h3, 1, "both_stable");
    rd(2'd3, 32'h3, 1, "both_edge");

    // partial clear, irq drops when bit0 gone; masking bit1 raises irq
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h2, 0, "partial_w1c");
    wr(2'd1, 32'h3);
    rd(2'd1, 32'h3, 1, "mask3");

    // edge set and cleared in the same cycle: set wins
    wr(2'd3, 32'h2);
    in_port = 4'h2;
    idle(8);
    rd(2'd3, 32'h0, 0, "edges_clear");
    in_port = 4'h3;
    idle(5);
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h1, 1, "set_beats_clr");
    rd(2'd3, 32'h1, 1, "set_holds");

    // period 0 behaves as 1: stable follows sync after one mismatch cycle
    wr(2'd2, 32'h0);
    rd(2'd2, 32'h0, 1, "period0");
    in_port = 4'h1;
    idle(2);
    rd(2'd0, 32'h3, 1, "p0_fall_early");
    rd(2'd0, 32'h1, 1, "p0_fall");
    in_port = 4'h3;
    idle(2);
    rd(2'd0, 32'h1, 1, "p0_rise_early");
    rd(2'd0, 32'h3, 1, "p0_rise");
    rd(2'd3, 32'h3, 1, "p0_edge");

    // read and write same address in one cycle returns old value
    rdwr(2'd1, 32'h1, 32'h3, 1, "rdwr_old");
    rd(2'd1, 32'h1, 1, "rdwr_new");

    // reset mid-debounce
    in_port = 4'h1;
    idle(4);
    wr(2'd3, 32'hF);
    wr(2'd2, 32'd4);
    in_port = 4'h3;
    idle(4);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    step();
    rd(2'd0, 32'h0, 0, "mid_rst_stable");
    rd(2'd1, 32'h0, 0, "mid_rst_mask");
    rd(2'd2, 32'h0000C350, 0, "mid_rst_period");
    rd(2'd3, 32'h0, 0, "mid_rst_edge");

    idle(2);
    if (sb_data.size() != 0) begin
      check_cnt++;
      $display("FAIL sb_drain: %0d entries left expected 0", sb_data.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/button_edge_ctrl.md
BUTTON_EDGE_CTRL -- requirements
Module: button_edge_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of button inputs, range 1..32.
REQ-002 SHALL have parameter CNT_W, default 16: debounce counter and period register width.
REQ-003 SHALL have parameter DEF_PERIOD, default 50000: reset value of the debounce period register.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port chipselect, input, 1: slave select.
REQ-007 SHALL have port address, input, 2: register select.
REQ-008 SHALL have port read, input, 1: read strobe.
REQ-009 SHALL have port write, input, 1: write strobe.
REQ-010 SHALL have port writedata, input, 32: write data.
REQ-011 SHALL have port readdata, output, 32: registered read data.
REQ-012 SHALL have port in_port, input, WIDTH: raw asynchronous button levels.
REQ-013 SHALL have port irq, output, 1: registered level interrupt.

Function
REQ-014 SHALL pass each in_port bit through a 2-flop synchronizer (sync); no other logic reads in_port.
REQ-015 SHALL keep per bit a debounced level stable[i] and a counter cnt[i] of CNT_W bits.
REQ-016 SHALL, per bit per cycle: if sync==stable, set cnt to 0.
REQ-017 SHALL, per bit per cycle: if sync!=stable and cnt==P-1, set stable to sync and cnt to 0; otherwise increment cnt.
REQ-018 SHALL use P = period register value, with P treated as 1 when the register holds 0.
REQ-019 SHALL reset all cnt to 0 in the cycle after a period write; stable SHALL be unaffected.
REQ-020 SHALL update stable on the P-th consecutive mismatching cycle; in_port-to-stable latency is 2+P cycles.
REQ-021 SHALL set edge[i] in the same cycle stable[i] transitions 0->1; 1->0 transitions SHALL NOT set edge.
REQ-022 SHALL use this register map: addr0 stable (RO, writes ignored); addr1 irq mask[WIDTH-1:0] (RW); addr2 period[CNT_W-1:0] (RW); addr3 edge[WIDTH-1:0] (read, write-1-to-clear).
REQ-023 SHALL, on a write to addr3 where a bit is both set by an edge and cleared by the write in the same cycle, leave that bit set.
REQ-024 SHALL register reads: readdata updates on the clock edge following a cycle with chipselect&read (1-cycle latency) and otherwise holds its value.
REQ-025 SHALL drive unimplemented readdata bits to 0.
REQ-026 SHALL accept writes only when chipselect&write; the write takes effect at that clock edge.
REQ-027 SHALL update irq each cycle as the OR of (edge & mask) from the previous cycle (1-cycle latency).
REQ-028 SHALL deassert irq in the cycle after the last contributing edge bit is cleared or masked.
REQ-029 SHALL ignore simultaneous read and write to the same address for ordering purposes: readdata returns the pre-write value.

Reset
REQ-030 SHALL, on reset_n low, asynchronously clear sync flops, stable, cnt, edge, mask, readdata and irq to 0, and load period with DEF_PERIOD.
REQ-031 SHALL discard any partially accumulated debounce count on reset mid-debounce; no edge SHALL be set by reset release.
REQ-032 SHALL release reset synchronously to clk, with no spurious edge or irq in the first cycle.

Verification
REQ-033 SHALL pass this scenario: period=4, in_port 0->0x1 held -> stable[0]=1 six cycles after change; edge=0x1; with mask=0x1, irq=1 one cycle later.
REQ-034 SHALL pass this scenario: period=4, bit0 glitch of 3 cycles -> stable, edge and irq remain 0; cnt returns to 0.
REQ-035 SHALL pass this scenario: edge=0x3, write addr3=0x1 -> edge=0x2 next cycle; read addr3 returns 0x00000002 one cycle after read strobe.
REQ-036 SHALL pass this scenario: edge set and W1C clear of the same bit in the same cycle -> bit remains 1; irq stays 1.
REQ-037 SHALL pass this scenario: period written 0 -> stable follows sync after 1 mismatching cycle; read addr2 returns 0x00000000.
REQ-038 SHALL pass this scenario: reset_n pulsed low mid-debounce (cnt=2) -> all registers at reset values, period reads 50000 (0x0000C350), irq=0.
